// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding and pipeline hazard control.
// Forwards results from MEM, WB, or a WB result captured during a memory
// freeze. It also generates load-use stalls/bubbles and variable-latency
// memory freezes, and keeps stall and timeout bookkeeping.
module forward_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 2,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_SRC*5-1:0]    i_id_rs,
    input  logic [NUM_SRC-1:0]      i_id_rs_used,
    input  logic [NUM_SRC*5-1:0]    i_ex_rs,
    input  logic [NUM_SRC*XLEN-1:0] i_ex_rf_data,
    input  logic [4:0]              i_ex_rd,
    input  logic                    i_ex_regwrite,
    input  logic                    i_ex_memread,
    input  logic [4:0]              i_mem_rd,
    input  logic                    i_mem_regwrite,
    input  logic                    i_mem_memread,
    input  logic [XLEN-1:0]         i_mem_alu_result,
    input  logic                    i_mem_ready,
    input  logic [4:0]              i_wb_rd,
    input  logic                    i_wb_regwrite,
    input  logic [XLEN-1:0]         i_wb_value,
    output logic [NUM_SRC*XLEN-1:0] o_ex_op,
    output logic [NUM_SRC*2-1:0]    o_fwd_sel,
    output logic                    o_stall_front,
    output logic                    o_bubble_ex,
    output logic                    o_freeze,
    output logic [CNT_W-1:0]        o_stall_cnt,
    output logic                    o_mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        SEL_RF   = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_WB   = 2'd2,
        SEL_HOLD = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              hold_valid_q, hold_valid_d;
    logic [4:0]        hold_rd_q, hold_rd_d;
    logic [XLEN-1:0]   hold_data_q, hold_data_d;

    logic freeze;
    logic load_use;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // A load sitting in MEM holds an address, not data, so it never forwards.
    assign mem_fwd_ok = i_mem_regwrite && !i_mem_memread && (i_mem_rd != 5'd0);
    assign wb_fwd_ok  = i_wb_regwrite && (i_wb_rd != 5'd0);
    assign freeze     = i_mem_memread && !i_mem_ready;

    // Per-operand source select, priority MEM > WB > HOLD > RF.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_fwd_sel = '0;
        o_ex_op   = i_ex_rf_data;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (mem_fwd_ok && (i_mem_rd == i_ex_rs[k*5 +: 5])) begin
                o_fwd_sel[k*2 +: 2]  = SEL_MEM;
                o_ex_op[k*XLEN +: XLEN] = i_mem_alu_result;
            end else if (wb_fwd_ok && (i_wb_rd == i_ex_rs[k*5 +: 5])) begin
                o_fwd_sel[k*2 +: 2]  = SEL_WB;
                o_ex_op[k*XLEN +: XLEN] = i_wb_value;
            end else if (hold_valid_q && (hold_rd_q == i_ex_rs[k*5 +: 5])) begin
                o_fwd_sel[k*2 +: 2]  = SEL_HOLD;
                o_ex_op[k*XLEN +: XLEN] = hold_data_q;
            end
        end
    end

    // Load in EX whose destination a used ID source needs next cycle.
    always_comb begin
        load_use = 1'b0;
        if (i_ex_memread && i_ex_regwrite && (i_ex_rd != 5'd0)) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (i_id_rs_used[k] && (i_id_rs[k*5 +: 5] == i_ex_rd)) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // A memory freeze outranks the load-use bubble: ID/EX must hold, not flush.
    assign o_freeze      = freeze;
    assign o_stall_front = freeze || load_use;
    assign o_bubble_ex   = load_use && !freeze;

    // RUN/WAIT next state and memory wait counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (freeze) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Leaving on !freeze covers the ready cycle and a cancelled load.
                if (!freeze) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Sticky timeout rises on the edge where the wait count reaches its limit.
    assign timeout_d = timeout_q || (wait_cnt_d == WAIT_W'(MAX_WAIT));

    // Saturating count of cycles with the front end stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall_front && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Capture the WB result leaving the pipeline on the first freeze edge.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        if (!freeze) begin
            hold_valid_d = 1'b0;
        end else if (!hold_valid_q && wb_fwd_ok) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = i_wb_rd;
            hold_data_d  = i_wb_value;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking (<=) for every register so all updates see pre-edge values.
        if (i_rst) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Hold payload register.
    always_ff @(posedge i_clk) begin
        // NOTE: payload has no reset; it is only ever read qualified by hold_valid_q.
        hold_rd_q   <= hold_rd_d;
        hold_data_q <= hold_data_d;
    end

    assign o_stall_cnt   = stall_cnt_q;
    assign o_mem_timeout = timeout_q;

endmodule

// File: doc/forward_hazard_unit.md
Name:
forward_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding logic, with these additions:
  - N source operands, XLEN-wide data.
  - Load-use stall and bubble generation.
  - Variable-latency data-memory wait handling.
  - A hold register, so a WB result that leaves the pipeline during a freeze is still forwardable.
  - Stall accounting and a memory-timeout error flag.
- Sits beside the ID/EX, EX/MEM and MEM/WB registers.
- Drives the EX operand values and every pipeline stall/flush control.

Parameters:
- XLEN, 32, datapath width.
- NUM_SRC, 2, number of source operands per instruction (operand k uses slice k of every packed bus).
- CNT_W, 16, width of the stall-cycle counter.
- MAX_WAIT, 64, memory-wait cycles before o_mem_timeout is raised.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_id_rs  in  NUM_SRC*5  ID-stage source register numbers.
- i_id_rs_used  in  NUM_SRC  ID source k is actually read.
- i_ex_rs  in  NUM_SRC*5  EX-stage source register numbers.
- i_ex_rf_data  in  NUM_SRC*XLEN  register-file operand values latched in ID/EX.
- i_ex_rd  in  5  EX destination.
- i_ex_regwrite  in  1  EX instruction writes rd.
- i_ex_memread  in  1  EX instruction is a load.
- i_mem_rd  in  5  MEM destination.
- i_mem_regwrite  in  1  MEM instruction writes rd.
- i_mem_memread  in  1  MEM instruction is a load.
- i_mem_alu_result  in  XLEN  MEM-stage ALU result.
- i_mem_ready  in  1  data memory completes this cycle.
- i_wb_rd  in  5  WB destination.
- i_wb_regwrite  in  1  WB instruction writes rd.
- i_wb_value  in  XLEN  final write-back value.
- o_ex_op  out  NUM_SRC*XLEN  forwarded EX operands.
- o_fwd_sel  out  NUM_SRC*2  per-operand source: 0 RF, 1 MEM, 2 WB, 3 HOLD.
- o_stall_front  out  1  hold PC and IF/ID.
- o_bubble_ex  out  1  load a bubble into ID/EX.
- o_freeze  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB.
- o_stall_cnt  out  CNT_W  saturating count of stalled cycles.
- o_mem_timeout  out  1  sticky memory-timeout error.

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including mid-wait:
  - state=RUN, hold_valid=0, wait_cnt=0, o_stall_cnt=0, o_mem_timeout=0.
  - Combinational outputs then reflect RUN with no hold.
- Forwarding (combinational, zero latency), per operand k, first match wins:
  - MEM: i_mem_regwrite, !i_mem_memread, i_mem_rd!=0, i_mem_rd==ex_rs[k].
  - WB: i_wb_regwrite, i_wb_rd!=0, rd match.
  - HOLD: hold_valid, hold_rd match.
  - Otherwise RF.
  - x0 never forwards.
  - A load in MEM never forwards its address.
- Load-use hazard (combinational):
  - Condition: i_ex_memread, i_ex_regwrite, i_ex_rd!=0, and some k with i_id_rs_used[k] && i_id_rs[k]==i_ex_rd.
  - Response: o_stall_front=1 and o_bubble_ex=1 for exactly that cycle, unless o_freeze=1, in which case freeze wins and o_bubble_ex=0.
- FSM states RUN and WAIT:
  - o_freeze = i_mem_memread && !i_mem_ready, in either state, combinational.
  - RUN -> WAIT when o_freeze.
  - WAIT -> RUN on the first cycle with i_mem_ready=1; that cycle has o_freeze=0.
  - o_stall_front=1 whenever o_freeze=1.
- Hold register:
  - Capture: on a clock edge where o_freeze=1 and hold_valid=0 and i_wb_regwrite && i_wb_rd!=0, capture hold_rd=i_wb_rd, hold_data=i_wb_value, hold_valid=1.
  - While hold_valid=1, no further capture.
  - Clear: hold_valid clears on any edge where o_freeze=0.
- wait_cnt:
  - Increments each WAIT cycle, saturating at MAX_WAIT.
  - Clears on WAIT->RUN.
  - o_mem_timeout sets when wait_cnt reaches MAX_WAIT and stays set until reset.
- o_stall_cnt increments by 1 each cycle with o_stall_front=1, saturating at 2^CNT_W-1.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: EX rs1=5, MEM rd=5 regwrite, alu=0x1234, WB rd=5 value=0xAAAA.
  - Required: o_fwd_sel[0]=1, o_ex_op[0]=0x1234.
  - With MEM regwrite deasserted instead: sel=2, op=0xAAAA.
- x0 and address guard:
  - Stimulus: MEM rd=0 regwrite, rs=0 → sel=0, RF data passes.
  - Stimulus: MEM is a load, rd=7, rs=7, WB rd=7 → sel=2, never 1.
- Load-use:
  - Stimulus: EX load rd=3, ID rs2=3 used → o_stall_front=1, o_bubble_ex=1 for one cycle; o_stall_cnt=1.
  - Stimulus: same with rs2 unused → no stall.
- Memory wait with hold:
  - Stimulus: MEM load, i_mem_ready low 3 cycles, WB rd=9 value=0x55 in the first freeze cycle, EX rs1=9.
  - Required: o_freeze=1 for 3 cycles; sel=3 with op=0x55 from cycle 2 onward; release cycle still forwards HOLD; hold clears after release; o_stall_cnt=3.
- Timeout:
  - Stimulus: MAX_WAIT=4, ready held low 6 cycles → o_mem_timeout rises after the 4th WAIT cycle and stays high after ready.
  - Stimulus: i_rst asserted mid-wait → next cycle all counters 0, timeout 0, hold invalid.
- Simultaneous events:
  - Stimulus: freeze and load-use condition together → o_freeze=1, o_bubble_ex=0; the bubble is issued on the release cycle if the hazard persists.
